// File: rtl/collision_scheduler.sv
// collision_scheduler: per-frame collision pass sequencer.
// Snapshots user/enemy positions on frame_tick, probes the projectile grid
// at each eligible enemy slot, checks user/enemy overlap, and maintains the
// score, health and game_over registers.
module collision_scheduler #(
  parameter int          NUM_ENEMIES = 4,
  parameter int          SCORE_W     = 16,
  parameter logic [3:0]  HEALTH_INIT = 4'd3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     frame_tick,
  input  logic [7:0]               user_x,
  input  logic [7:0]               user_y,
  input  logic [8*NUM_ENEMIES-1:0] enemy_x,
  input  logic [8*NUM_ENEMIES-1:0] enemy_y,
  input  logic [NUM_ENEMIES-1:0]   enemy_valid,
  output logic                     rd_en,
  output logic [7:0]               rd_x,
  output logic [7:0]               rd_y,
  input  logic                     rd_data,
  output logic [SCORE_W-1:0]       score,
  output logic [3:0]               health,
  output logic                     game_over,
  output logic [NUM_ENEMIES-1:0]   enemy_kill,
  output logic                     busy,
  output logic                     done
);

  localparam int IW = (NUM_ENEMIES > 1) ? $clog2(NUM_ENEMIES) : 1;

  typedef enum logic [2:0] {IDLE, ISSUE, CAPTURE, USER, DONE} state_t;

  state_t                 state;
  logic [IW-1:0]          idx;
  logic [NUM_ENEMIES-1:0] kill;
  logic [7:0]             sx [NUM_ENEMIES];
  logic [7:0]             sy [NUM_ENEMIES];
  logic [NUM_ENEMIES-1:0] sv;
  logic [7:0]             ux_q;
  logic [7:0]             uy_q;
  logic [7:0]             rd_x_q;
  logic [7:0]             rd_y_q;

  logic [NUM_ENEMIES-1:0] elig;
  logic                   overlap;
  logic                   cur_elig;
  logic                   last;

  // Slot eligibility and user overlap, derived from the snapshot only
  always_comb begin
    elig    = '0;
    overlap = 1'b0;
    for (int unsigned i = 0; i < NUM_ENEMIES; i++) begin
      elig[i] = sv[i] && (sx[i] < 8'd160) && (sy[i] < 8'd120);
      if (elig[i] && !kill[i] && (sx[i] == ux_q) && (sy[i] == uy_q))
        overlap = 1'b1;
    end
    cur_elig = elig[idx];
    last     = (idx == IW'(NUM_ENEMIES - 1));
  end

  // Pass sequencer, snapshot, score/health bookkeeping
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= '0;
      kill      <= '0;
      sv        <= '0;
      ux_q      <= '0;
      uy_q      <= '0;
      rd_x_q    <= '0;
      rd_y_q    <= '0;
      score     <= '0;
      health    <= HEALTH_INIT;
      game_over <= 1'b0;
      for (int unsigned i = 0; i < NUM_ENEMIES; i++) begin
        sx[i] <= '0;
        sy[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (frame_tick && !game_over) begin
            for (int unsigned i = 0; i < NUM_ENEMIES; i++) begin
              sx[i] <= enemy_x[8*i +: 8];
              sy[i] <= enemy_y[8*i +: 8];
            end
            sv    <= enemy_valid;
            ux_q  <= user_x;
            uy_q  <= user_y;
            kill  <= '0;
            idx   <= '0;
            state <= ISSUE;
          end
        end
        ISSUE: begin
          if (cur_elig) begin
            rd_x_q <= sx[idx];
            rd_y_q <= sy[idx];
            state  <= CAPTURE;
          end else if (last) begin
            state <= USER;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        CAPTURE: begin
          if (rd_data) begin
            kill[idx] <= 1'b1;
            if (score != '1)
              score <= score + SCORE_W'(1);
          end
          if (last) begin
            state <= USER;
          end else begin
            idx   <= idx + IW'(1);
            state <= ISSUE;
          end
        end
        USER: begin
          if (overlap) begin
            if (health != 4'd0)
              health <= health - 4'd1;
            if (health <= 4'd1)
              game_over <= 1'b1;
          end
          state <= DONE;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decoded from registered state; read address holds between reads
  always_comb begin
    busy       = (state != IDLE);
    done       = (state == DONE);
    enemy_kill = (state == DONE) ? kill : '0;
    rd_en      = (state == ISSUE) && cur_elig;
    rd_x       = rd_en ? sx[idx] : rd_x_q;
    rd_y       = rd_en ? sy[idx] : rd_y_q;
  end

endmodule

// File: tb/tb_collision_scheduler.sv
// Self-checking bench for collision_scheduler: table vectors, reset-abort
// sequence, and randomized passes against a behavioural model. A second
// instance with a 2-bit score shares all inputs to exercise saturation.
module tb_collision_scheduler;
  localparam int NE = 4;

  logic            clk = 1'b0;
  logic            reset, frame_tick, rd_data;
  logic [7:0]      user_x, user_y;
  logic [8*NE-1:0] enemy_x, enemy_y;
  logic [NE-1:0]   enemy_valid;

  logic            rd_en, game_over, busy, done;
  logic [7:0]      rd_x, rd_y;
  logic [15:0]     score;
  logic [3:0]      health;
  logic [NE-1:0]   enemy_kill;

  logic            rd_en2, game_over2, busy2, done2;
  logic [7:0]      rd_x2, rd_y2;
  logic [1:0]      score2;
  logic [3:0]      health2;
  logic [NE-1:0]   enemy_kill2;

  collision_scheduler #(.NUM_ENEMIES(NE), .SCORE_W(16), .HEALTH_INIT(4'd3)) dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .user_x(user_x), .user_y(user_y),
    .enemy_x(enemy_x), .enemy_y(enemy_y), .enemy_valid(enemy_valid),
    .rd_en(rd_en), .rd_x(rd_x), .rd_y(rd_y), .rd_data(rd_data),
    .score(score), .health(health), .game_over(game_over), .enemy_kill(enemy_kill),
    .busy(busy), .done(done));

  collision_scheduler #(.NUM_ENEMIES(NE), .SCORE_W(2), .HEALTH_INIT(4'd3)) dut2 (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .user_x(user_x), .user_y(user_y),
    .enemy_x(enemy_x), .enemy_y(enemy_y), .enemy_valid(enemy_valid),
    .rd_en(rd_en2), .rd_x(rd_x2), .rd_y(rd_y2), .rd_data(rd_data),
    .score(score2), .health(health2), .game_over(game_over2), .enemy_kill(enemy_kill2),
    .busy(busy2), .done(done2));

  always #5 clk = ~clk;

  // Projectile grid memory: data appears the cycle after a read strobe
  bit grid [160][120];
  always @(posedge clk)
    rd_data <= (rd_en && rd_x < 8'd160 && rd_y < 8'd120) ? grid[rd_x][rd_y]
                                                        : 1'($urandom_range(0, 1));

  int          vec_cnt = 0, miscmp = 0, pass_no = 0;
  int          m_score, m_score2;
  logic [3:0]  m_health;
  bit          m_go;
  logic [15:0] last_rd;

  typedef struct {
    logic [31:0] ex, ey;
    logic [3:0]  ev;
    logic [7:0]  ux, uy;
    logic [3:0]  proj;
    bit          extra;
    logic [3:0]  kill;
    int          score;
    logic [3:0]  health;
    bit          go;
    int          done;
  } vec_t;
  vec_t tbl [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miscmp++;
      $display("FAIL %s (pass %0d): got %0d expected %0d", name, pass_no, act, exp);
    end
  endtask

  task automatic clear_grid();
    for (int x = 0; x < 160; x++)
      for (int y = 0; y < 120; y++)
        grid[x][y] = 1'b0;
  endtask

  task automatic set_proj(input logic [31:0] ex, ey, input logic [3:0] proj);
    for (int i = 0; i < NE; i++)
      if (proj[i] && ex[8*i +: 8] < 8'd160 && ey[8*i +: 8] < 8'd120)
        grid[ex[8*i +: 8]][ey[8*i +: 8]] = 1'b1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    frame_tick = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    m_score = 0; m_score2 = 0; m_health = 4'd3; m_go = 1'b0; last_rd = '0;
  endtask

  // Behavioural expectation of one pass from the current model state
  task automatic model(input logic [31:0] ex, ey, input logic [3:0] ev, input logic [7:0] ux, uy,
                       output logic [3:0] ekill, output int escore, output logic [3:0] ehealth,
                       output bit ego, output int edone);
    int e = 0;
    bit ov = 0;
    ekill = '0;
    if (m_go) begin
      escore = m_score; ehealth = m_health; ego = 1'b1; edone = 0;
      return;
    end
    for (int i = 0; i < NE; i++) begin
      logic [7:0] x, y;
      x = ex[8*i +: 8];
      y = ey[8*i +: 8];
      if (ev[i] && x < 160 && y < 120) begin
        e++;
        if (grid[x][y]) ekill[i] = 1'b1;
        else if (x == ux && y == uy) ov = 1'b1;
      end
    end
    escore  = m_score + $countones(ekill);
    if (escore > 65535) escore = 65535;
    ehealth = (ov && m_health != 0) ? m_health - 4'd1 : m_health;
    ego     = ov && (ehealth == 0);
    edone   = 1 + 2 * e + (NE - e) + 1;
  endtask

  // Apply one frame_tick and check the whole pass cycle by cycle
  task automatic run_pass(input string tag, input logic [31:0] ex, ey, input logic [3:0] ev,
                          input logic [7:0] ux, uy, input bit extra, input logic [3:0] ekill,
                          input int escore, input logic [3:0] ehealth, input bit ego, input int edone);
    logic [15:0] rq[$];
    int cyc, nreads, nexp, exp_s2;
    pass_no++;
    if (edone != 0)
      for (int i = 0; i < NE; i++)
        if (ev[i] && ex[8*i +: 8] < 8'd160 && ey[8*i +: 8] < 8'd120)
          rq.push_back({ex[8*i +: 8], ey[8*i +: 8]});
    nexp = rq.size();
    enemy_x = ex; enemy_y = ey; enemy_valid = ev; user_x = ux; user_y = uy;
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    enemy_x = $urandom; enemy_y = $urandom; enemy_valid = 4'($urandom);
    user_x = 8'($urandom); user_y = 8'($urandom);
    cyc = 1;
    nreads = 0;
    forever begin
      chk({tag, ":busy"}, busy, (edone != 0 && cyc <= edone));
      chk({tag, ":done"}, done, (cyc == edone));
      chk({tag, ":kill"}, enemy_kill, (cyc == edone) ? ekill : 4'h0);
      if (rd_en) begin
        nreads++;
        if (rq.size() > 0) begin
          last_rd = rq.pop_front();
          chk({tag, ":rd_xy"}, {rd_x, rd_y}, last_rd);
        end
      end else begin
        chk({tag, ":rd_hold"}, {rd_x, rd_y}, last_rd);
      end
      if (cyc >= ((edone != 0) ? edone + 1 : 12)) break;
      frame_tick = extra && (cyc == 2);
      @(negedge clk);
      cyc++;
    end
    frame_tick = 1'b0;
    exp_s2 = m_score2 + $countones(ekill);
    if (exp_s2 > 3) exp_s2 = 3;
    chk({tag, ":nreads"}, nreads, nexp);
    chk({tag, ":score"}, score, escore);
    chk({tag, ":score2"}, score2, exp_s2);
    chk({tag, ":health"}, health, ehealth);
    chk({tag, ":game_over"}, game_over, ego);
    m_score = escore; m_score2 = exp_s2; m_health = ehealth; m_go = ego;
  endtask

  initial begin
    logic [31:0] ex, ey;
    logic [3:0]  ev, proj, ekill;
    logic [7:0]  ux, uy;
    int          escore, edone;
    logic [3:0]  ehealth;
    bit          ego;

    reset = 1'b1; frame_tick = 1'b0; user_x = '0; user_y = '0;
    enemy_x = '0; enemy_y = '0; enemy_valid = '0;
    clear_grid();
    do_reset();

    chk("rst:score", score, 0);
    chk("rst:score2", score2, 0);
    chk("rst:health", health, 3);
    chk("rst:game_over", game_over, 0);
    chk("rst:kill", enemy_kill, 0);
    chk("rst:busy", busy, 0);
    chk("rst:done", done, 0);
    chk("rst:rd_en", rd_en, 0);
    chk("rst:rd_xy", {rd_x, rd_y}, 0);

    tbl[0] = '{{8'd70, 8'd50, 8'd30, 8'd10}, {8'd80, 8'd60, 8'd40, 8'd20}, 4'hf, 8'd0, 8'd0,
               4'h0, 1'b1, 4'h0, 0, 4'd3, 1'b0, 10};
    tbl[1] = '{{8'd70, 8'd50, 8'd30, 8'd10}, {8'd80, 8'd60, 8'd40, 8'd20}, 4'hf, 8'd0, 8'd0,
               4'ha, 1'b0, 4'ha, 2, 4'd3, 1'b0, 10};
    tbl[2] = '{{8'd0, 8'd0, 8'd0, 8'd40}, {8'd0, 8'd0, 8'd0, 8'd60}, 4'h1, 8'd40, 8'd60,
               4'h0, 1'b0, 4'h0, 2, 4'd2, 1'b0, 7};
    tbl[3] = '{{8'd0, 8'd0, 8'd0, 8'd40}, {8'd0, 8'd0, 8'd0, 8'd60}, 4'h1, 8'd40, 8'd60,
               4'h1, 1'b0, 4'h1, 3, 4'd2, 1'b0, 7};
    tbl[4] = '{{8'd9, 8'd160, 8'd6, 8'd5}, {8'd9, 8'd10, 8'd6, 8'd5}, 4'h7, 8'd1, 8'd1,
               4'h0, 1'b1, 4'h0, 3, 4'd2, 1'b0, 8};
    tbl[5] = '{{8'd0, 8'd0, 8'd40, 8'd40}, {8'd0, 8'd0, 8'd60, 8'd60}, 4'h3, 8'd40, 8'd60,
               4'h0, 1'b0, 4'h0, 3, 4'd1, 1'b0, 8};
    tbl[6] = '{{8'd0, 8'd0, 8'd40, 8'd40}, {8'd0, 8'd0, 8'd60, 8'd60}, 4'h3, 8'd40, 8'd60,
               4'h0, 1'b0, 4'h0, 3, 4'd0, 1'b1, 8};
    tbl[7] = '{{8'd0, 8'd0, 8'd40, 8'd40}, {8'd0, 8'd0, 8'd60, 8'd60}, 4'h3, 8'd40, 8'd60,
               4'h0, 1'b0, 4'h0, 3, 4'd0, 1'b1, 0};

    for (int i = 0; i < 8; i++) begin
      clear_grid();
      set_proj(tbl[i].ex, tbl[i].ey, tbl[i].proj);
      run_pass($sformatf("t%0d", i), tbl[i].ex, tbl[i].ey, tbl[i].ev, tbl[i].ux, tbl[i].uy,
               tbl[i].extra, tbl[i].kill, tbl[i].score, tbl[i].health, tbl[i].go, tbl[i].done);
    end

    // Reset asserted during CAPTURE of slot 0 (which would have hit)
    do_reset();
    clear_grid();
    grid[10][20] = 1'b1;
    enemy_x = {8'd70, 8'd50, 8'd30, 8'd10};
    enemy_y = {8'd80, 8'd60, 8'd40, 8'd20};
    enemy_valid = 4'hf; user_x = 8'd0; user_y = 8'd0;
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort:busy", busy, 0);
    chk("abort:score", score, 0);
    chk("abort:health", health, 3);
    chk("abort:rd_en", rd_en, 0);
    chk("abort:rd_xy", {rd_x, rd_y}, 0);
    chk("abort:kill", enemy_kill, 0);
    for (int c = 0; c < 12; c++) begin
      chk("abort:done", done, 0);
      @(negedge clk);
    end
    chk("abort:score_after", score, 0);

    // Randomized passes against the behavioural model
    do_reset();
    for (int n = 0; n < 60; n++) begin
      ux = 8'($urandom_range(0, 159));
      uy = 8'($urandom_range(0, 119));
      for (int i = 0; i < NE; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          ex[8*i +: 8] = ux; ey[8*i +: 8] = uy;
        end else begin
          ex[8*i +: 8] = 8'($urandom_range(0, 170));
          ey[8*i +: 8] = 8'($urandom_range(0, 127));
        end
      end
      ev = 4'($urandom);
      proj = 4'($urandom) & 4'($urandom);
      clear_grid();
      set_proj(ex, ey, proj);
      model(ex, ey, ev, ux, uy, ekill, escore, ehealth, ego, edone);
      run_pass($sformatf("r%0d", n), ex, ey, ev, ux, uy, 1'($urandom_range(0, 1)),
               ekill, escore, ehealth, ego, edone);
      if (m_go && edone == 0) do_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp);
    $finish;
  end
endmodule
